// File: rtl/tx_host_ctrl.sv
// tx_host_ctrl: turns host command/data bytes into transmitter write strobes,
// write-index save/restore, frame commits, status read-back and a TX-done interrupt.
module tx_host_ctrl #(
   parameter int BUF_BYTES = 1024,
   parameter int TIMEOUT   = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_sync,
   input  logic        i_cmd,
   input  logic [7:0]  i_data,
   output logic [7:0]  o_data,
   output logic        o_sync,
   output logic        o_tx_int,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_data_we,
   output logic        o_push_write_index,
   output logic        o_pop_write_index,
   output logic        o_push_frame,
   input  logic [15:0] i_data_size,
   input  logic [7:0]  i_frames_count,
   input  logic [7:0]  i_status
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [7:0] CMD_BEGIN   = 8'h01;
   localparam logic [7:0] CMD_ABORT   = 8'h02;
   localparam logic [7:0] CMD_STATUS  = 8'h03;
   localparam logic [7:0] CMD_INT_ACK = 8'h04;

   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [7:0]       len_lo_q, len_lo_d;
   logic [15:0]      remaining_q, remaining_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             err_q, err_d;
   logic             commit_q, commit_d;
   logic [2:0]       resp_idx_q, resp_idx_d;
   logic [31:0]      snap_q, snap_d;
   logic [7:0]       fc_q, fc_d, fc_prev_q, fc_prev_d;
   logic [7:0]       data_q, data_d;
   logic             sync_q, sync_d;
   logic             tx_int_q, tx_int_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_we_q, tx_we_d;
   logic             push_wi_q, push_wi_d;
   logic             pop_wi_q, pop_wi_d;
   logic             push_frame_q, push_frame_d;

   logic        is_cmd, is_dat, int_ack, len_ok;
   logic [15:0] len_full;
   logic [16:0] fill_sum;

   assign is_cmd   = i_sync & i_cmd;
   assign is_dat   = i_sync & ~i_cmd;
   assign len_full = {i_data, len_lo_q};
   // 17-bit sum so a near-full buffer plus a large length cannot wrap past the check
   assign fill_sum = {1'b0, i_data_size} + {1'b0, len_full};
   assign len_ok   = (len_full != 16'd0) && (fill_sum <= 17'(BUF_BYTES));

   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      remaining_d  = remaining_q;
      idle_cnt_d   = '0;
      err_d        = err_q;
      commit_d     = 1'b0;
      resp_idx_d   = resp_idx_q;
      snap_d       = snap_q;
      fc_d         = i_frames_count;
      fc_prev_d    = fc_q;
      data_d       = data_q;
      sync_d       = 1'b0;
      tx_data_d    = tx_data_q;
      tx_we_d      = 1'b0;
      push_wi_d    = 1'b0;
      pop_wi_d     = 1'b0;
      push_frame_d = commit_q;
      int_ack      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_cmd) begin
               case (i_data)
                  CMD_BEGIN:   state_d = S_LEN_LO;
                  CMD_ABORT:   ;
                  CMD_STATUS: begin
                     data_d     = {5'b0, 1'b0, tx_int_q, err_q};
                     sync_d     = 1'b1;
                     snap_d     = {i_data_size[15:8], i_data_size[7:0], i_frames_count, i_status};
                     resp_idx_d = 3'd1;
                     err_d      = 1'b0;
                     state_d    = S_RESP;
                  end
                  CMD_INT_ACK: int_ack = 1'b1;
                  default:     err_d = 1'b1;
               endcase
            end else if (is_dat) begin
               err_d = 1'b1;
            end
         end
         S_LEN_LO, S_LEN_HI: begin
            if (is_cmd) begin
               if (i_data == CMD_ABORT) state_d = S_IDLE;
               else                     err_d   = 1'b1;
            end else if (is_dat) begin
               if (state_q == S_LEN_LO) begin
                  len_lo_d = i_data;
                  state_d  = S_LEN_HI;
               end else if (len_ok) begin
                  push_wi_d   = 1'b1;
                  remaining_d = len_full;
                  state_d     = S_LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_LOAD: begin
            if (is_cmd) begin
               if (i_data == CMD_ABORT) begin
                  pop_wi_d = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end else if (is_dat) begin
               tx_we_d     = 1'b1;
               tx_data_d   = i_data;
               remaining_d = remaining_q - 16'd1;
               if (remaining_q == 16'd1) begin
                  commit_d = 1'b1;
                  state_d  = S_IDLE;
               end
            end
         end
         S_RESP: begin
            if (i_sync) err_d = 1'b1;
            if (resp_idx_q == 3'd5) begin
               state_d = S_IDLE;
            end else begin
               sync_d     = 1'b1;
               data_d     = snap_q[7:0];
               snap_d     = {8'h00, snap_q[31:8]};
               resp_idx_d = resp_idx_q + 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Host inactivity watchdog for the multi-byte frame load
      if (state_q == S_LEN_LO || state_q == S_LEN_HI || state_q == S_LOAD) begin
         if (i_sync) begin
            idle_cnt_d = '0;
         end else if (idle_cnt_q == CNT_W'(TIMEOUT)) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            pop_wi_d = (state_q == S_LOAD);
         end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
         end
      end

      tx_int_d = (fc_q < fc_prev_q) | (tx_int_q & ~int_ack);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         len_lo_q     <= '0;
         remaining_q  <= '0;
         idle_cnt_q   <= '0;
         err_q        <= 1'b0;
         commit_q     <= 1'b0;
         resp_idx_q   <= '0;
         snap_q       <= '0;
         fc_q         <= '0;
         fc_prev_q    <= '0;
         data_q       <= '0;
         sync_q       <= 1'b0;
         tx_int_q     <= 1'b0;
         tx_data_q    <= '0;
         tx_we_q      <= 1'b0;
         push_wi_q    <= 1'b0;
         pop_wi_q     <= 1'b0;
         push_frame_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         remaining_q  <= remaining_d;
         idle_cnt_q   <= idle_cnt_d;
         err_q        <= err_d;
         commit_q     <= commit_d;
         resp_idx_q   <= resp_idx_d;
         snap_q       <= snap_d;
         fc_q         <= fc_d;
         fc_prev_q    <= fc_prev_d;
         data_q       <= data_d;
         sync_q       <= sync_d;
         tx_int_q     <= tx_int_d;
         tx_data_q    <= tx_data_d;
         tx_we_q      <= tx_we_d;
         push_wi_q    <= push_wi_d;
         pop_wi_q     <= pop_wi_d;
         push_frame_q <= push_frame_d;
      end
   end

   assign o_data             = data_q;
   assign o_sync             = sync_q;
   assign o_tx_int           = tx_int_q;
   assign o_tx_data          = tx_data_q;
   assign o_tx_data_we       = tx_we_q;
   assign o_push_write_index = push_wi_q;
   assign o_pop_write_index  = pop_wi_q;
   assign o_push_frame       = push_frame_q;
endmodule

// File: tb/tb_tx_host_ctrl.sv
// Bench for tx_host_ctrl: directed scenarios plus randomized frames checked
// against a frame-level model of expected writes, commits, restores and status.
module tb_tx_host_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_sync = 1'b0;
   logic        i_cmd = 1'b0;
   logic [7:0]  i_data = 8'h00;
   logic [15:0] i_data_size = 16'h0000;
   logic [7:0]  i_frames_count = 8'h00;
   logic [7:0]  i_status = 8'h00;
   logic [7:0]  o_data;
   logic        o_sync;
   logic        o_tx_int;
   logic [7:0]  o_tx_data;
   logic        o_tx_data_we;
   logic        o_push_write_index;
   logic        o_pop_write_index;
   logic        o_push_frame;

   int n_cmp = 0;
   int n_err = 0;
   logic exp_err = 1'b0;
   logic exp_int = 1'b0;

   logic [7:0] wr_log[$];
   int n_pwi = 0;
   int n_pop = 0;
   int n_pf  = 0;

   tx_host_ctrl #(.BUF_BYTES(1024), .TIMEOUT(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_sync(i_sync), .i_cmd(i_cmd), .i_data(i_data),
      .o_data(o_data), .o_sync(o_sync), .o_tx_int(o_tx_int), .o_tx_data(o_tx_data),
      .o_tx_data_we(o_tx_data_we), .o_push_write_index(o_push_write_index),
      .o_pop_write_index(o_pop_write_index), .o_push_frame(o_push_frame),
      .i_data_size(i_data_size), .i_frames_count(i_frames_count), .i_status(i_status)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_tx_data_we) wr_log.push_back(o_tx_data);
      if (o_push_write_index) n_pwi++;
      if (o_pop_write_index) n_pop++;
      if (o_push_frame) n_pf++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic cmd, input logic [7:0] d);
      i_sync = 1'b1;
      i_cmd  = cmd;
      i_data = d;
      @(posedge i_clk);
      #1;
      i_sync = 1'b0;
      i_cmd  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_rst  = 1'b1;
      i_sync = 1'b0;
      i_cmd  = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst   = 1'b0;
      exp_err = 1'b0;
      exp_int = 1'b0;
   endtask

   task automatic read_status(input string tag);
      logic [7:0] eb[5];
      eb[0] = {6'b0, exp_int, exp_err};
      eb[1] = i_status;
      eb[2] = i_frames_count;
      eb[3] = i_data_size[7:0];
      eb[4] = i_data_size[15:8];
      send_byte(1'b1, 8'h03);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) idle(1);
         n_cmp++;
         if (o_sync !== 1'b1 || o_data !== eb[k]) begin
            n_err++;
            $display("FAIL %s status byte %0d: got sync=%b data=%h, required sync=1 data=%h",
                     tag, k, o_sync, o_data, eb[k]);
         end
      end
      idle(1);
      n_cmp++;
      if (o_sync !== 1'b0) begin
         n_err++;
         $display("FAIL %s status end: got o_sync=%b, required 0", tag, o_sync);
      end
      exp_err = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      i_rst = 1'b1;
      i_data_size = 16'h0000;
      i_status = 8'h00;
      i_frames_count = 8'h00;
      repeat (3) @(posedge i_clk);
      #1;
      outs = {o_sync, o_tx_int, o_tx_data_we, o_push_write_index, o_pop_write_index,
              o_push_frame, 2'b00};
      n_cmp++;
      if (outs !== 8'h00 || o_data !== 8'h00 || o_tx_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset outputs: got flags=%h data=%h tx_data=%h, required all 0",
                  outs, o_data, o_tx_data);
      end
      i_rst = 1'b0;
      exp_err = 1'b0;
      exp_int = 1'b0;
      idle(2);
      read_status("reset");
      $display("test_reset done");
   endtask

   task automatic test_normal_frame();
      int b_wr = wr_log.size();
      int b_pwi = n_pwi, b_pf = n_pf, b_pop = n_pop;
      logic [7:0] pl[3];
      pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
      i_data_size = 16'd0;
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h03);
      n_cmp++;
      if (o_push_write_index !== 1'b0) begin
         n_err++;
         $display("FAIL normal early push_wi: got %b, required 0", o_push_write_index);
      end
      send_byte(1'b0, 8'h00);
      n_cmp++;
      if (o_push_write_index !== 1'b1) begin
         n_err++;
         $display("FAIL normal push_wi latency: got %b, required 1", o_push_write_index);
      end
      for (int i = 0; i < 3; i++) begin
         send_byte(1'b0, pl[i]);
         n_cmp++;
         if (o_tx_data_we !== 1'b1 || o_tx_data !== pl[i] || o_push_frame !== 1'b0) begin
            n_err++;
            $display("FAIL normal write %0d: got we=%b data=%h pf=%b, required we=1 data=%h pf=0",
                     i, o_tx_data_we, o_tx_data, o_push_frame, pl[i]);
         end
      end
      idle(1);
      n_cmp++;
      if (o_push_frame !== 1'b1 || o_tx_data_we !== 1'b0) begin
         n_err++;
         $display("FAIL normal commit t+2: got pf=%b we=%b, required pf=1 we=0",
                  o_push_frame, o_tx_data_we);
      end
      idle(2);
      n_cmp++;
      if (n_pwi - b_pwi !== 1 || n_pf - b_pf !== 1 || n_pop - b_pop !== 0 || wr_log.size() - b_wr !== 3) begin
         n_err++;
         $display("FAIL normal counts: got pwi=%0d pf=%0d pop=%0d wr=%0d, required 1/1/0/3",
                  n_pwi - b_pwi, n_pf - b_pf, n_pop - b_pop, wr_log.size() - b_wr);
      end
      read_status("normal");
      $display("test_normal_frame done");
   endtask

   task automatic test_overflow();
      int b_wr = wr_log.size();
      int b_pwi = n_pwi, b_pf = n_pf, b_pop = n_pop;
      i_data_size = 16'd1020;
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h05);
      send_byte(1'b0, 8'h00);
      exp_err = 1'b1;
      n_cmp++;
      if (o_push_write_index !== 1'b0) begin
         n_err++;
         $display("FAIL overflow push_wi: got %b, required 0", o_push_write_index);
      end
      idle(3);
      n_cmp++;
      if (n_pwi != b_pwi || n_pf != b_pf || n_pop != b_pop || wr_log.size() != b_wr) begin
         n_err++;
         $display("FAIL overflow strobes: got pwi=%0d pf=%0d pop=%0d wr=%0d, required none",
                  n_pwi - b_pwi, n_pf - b_pf, n_pop - b_pop, wr_log.size() - b_wr);
      end
      read_status("overflow");
      // exactly filling the buffer is allowed
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h04);
      send_byte(1'b0, 8'h00);
      n_cmp++;
      if (o_push_write_index !== 1'b1) begin
         n_err++;
         $display("FAIL exact-fit push_wi: got %b, required 1", o_push_write_index);
      end
      send_byte(1'b1, 8'h02);
      n_cmp++;
      if (o_pop_write_index !== 1'b1) begin
         n_err++;
         $display("FAIL exact-fit abort pop: got %b, required 1", o_pop_write_index);
      end
      i_data_size = 16'd0;
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'h00);
      exp_err = 1'b1;
      n_cmp++;
      if (o_push_write_index !== 1'b0) begin
         n_err++;
         $display("FAIL zero-len push_wi: got %b, required 0", o_push_write_index);
      end
      idle(2);
      read_status("zero_len");
      $display("test_overflow done");
   endtask

   task automatic test_abort();
      int b_wr = wr_log.size();
      int b_pwi = n_pwi, b_pf = n_pf, b_pop = n_pop;
      i_data_size = 16'd0;
      send_byte(1'b1, 8'h01);
      send_byte(1'b1, 8'h02);
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h04);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'h11);
      send_byte(1'b0, 8'h22);
      send_byte(1'b1, 8'h02);
      n_cmp++;
      if (o_pop_write_index !== 1'b1) begin
         n_err++;
         $display("FAIL abort pop latency: got %b, required 1", o_pop_write_index);
      end
      idle(4);
      n_cmp++;
      if (n_pwi - b_pwi !== 1 || n_pf - b_pf !== 0 || n_pop - b_pop !== 1 || wr_log.size() - b_wr !== 2) begin
         n_err++;
         $display("FAIL abort counts: got pwi=%0d pf=%0d pop=%0d wr=%0d, required 1/0/1/2",
                  n_pwi - b_pwi, n_pf - b_pf, n_pop - b_pop, wr_log.size() - b_wr);
      end
      read_status("abort");
      send_byte(1'b0, 8'h33);
      exp_err = 1'b1;
      n_cmp++;
      if (o_tx_data_we !== 1'b0) begin
         n_err++;
         $display("FAIL idle data byte: got we=%b, required 0", o_tx_data_we);
      end
      idle(1);
      read_status("idle_data");
      $display("test_abort done");
   endtask

   task automatic test_timeout();
      int b_pop = n_pop;
      int hit = -1;
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h02);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'h77);
      for (int k = 1; k <= 22; k++) begin
         idle(1);
         if (o_pop_write_index === 1'b1 && hit < 0) hit = k;
      end
      n_cmp++;
      if (hit < 16 || hit > 17 || n_pop - b_pop !== 1) begin
         n_err++;
         $display("FAIL timeout pop: got idle cycle %0d count %0d, required cycle 16..17 count 1",
                  hit, n_pop - b_pop);
      end
      exp_err = 1'b1;
      read_status("timeout_load");
      b_pop = n_pop;
      send_byte(1'b1, 8'h01);
      idle(22);
      exp_err = 1'b1;
      n_cmp++;
      if (n_pop != b_pop) begin
         n_err++;
         $display("FAIL timeout len pop: got %0d, required 0", n_pop - b_pop);
      end
      read_status("timeout_len");
      $display("test_timeout done");
   endtask

   task automatic test_status();
      i_status = 8'h5A;
      i_frames_count = 8'd3;
      i_data_size = 16'h0123;
      idle(3);
      read_status("status");
      send_byte(1'b1, 8'h03);
      send_byte(1'b0, 8'h99);
      n_cmp++;
      if (o_sync !== 1'b1 || o_data !== 8'h5A) begin
         n_err++;
         $display("FAIL status with host byte: got sync=%b data=%h, required 1/5a", o_sync, o_data);
      end
      idle(4);
      n_cmp++;
      if (o_sync !== 1'b0) begin
         n_err++;
         $display("FAIL status length: got o_sync=%b, required 0", o_sync);
      end
      exp_err = 1'b1;
      read_status("status_drop");
      $display("test_status done");
   endtask

   task automatic test_interrupt();
      i_rst = 1'b1;
      i_frames_count = 8'd2;
      do_reset();
      idle(3);
      i_frames_count = 8'd1;
      idle(1);
      n_cmp++;
      if (o_tx_int !== 1'b0) begin
         n_err++;
         $display("FAIL int early: got %b, required 0", o_tx_int);
      end
      idle(1);
      n_cmp++;
      if (o_tx_int !== 1'b1) begin
         n_err++;
         $display("FAIL int latency: got %b, required 1", o_tx_int);
      end
      i_frames_count = 8'd0;
      idle(1);
      send_byte(1'b1, 8'h04);
      n_cmp++;
      if (o_tx_int !== 1'b1) begin
         n_err++;
         $display("FAIL int set-vs-ack: got %b, required 1", o_tx_int);
      end
      idle(2);
      send_byte(1'b1, 8'h04);
      n_cmp++;
      if (o_tx_int !== 1'b0) begin
         n_err++;
         $display("FAIL int ack: got %b, required 0", o_tx_int);
      end
      i_frames_count = 8'd5;
      idle(3);
      n_cmp++;
      if (o_tx_int !== 1'b0) begin
         n_err++;
         $display("FAIL int on rise: got %b, required 0", o_tx_int);
      end
      i_frames_count = 8'd4;
      idle(3);
      exp_int = 1'b1;
      read_status("int_status");
      send_byte(1'b1, 8'h04);
      exp_int = 1'b0;
      idle(1);
      read_status("int_cleared");
      $display("test_interrupt done");
   endtask

   task automatic test_reset_mid_load();
      int b_pop, b_pf;
      i_data_size = 16'd0;
      send_byte(1'b1, 8'h01);
      send_byte(1'b0, 8'h04);
      send_byte(1'b0, 8'h00);
      send_byte(1'b0, 8'h55);
      idle(1);
      b_pop = n_pop;
      b_pf = n_pf;
      do_reset();
      idle(20);
      n_cmp++;
      if (n_pop != b_pop || n_pf != b_pf) begin
         n_err++;
         $display("FAIL reset mid-load strobes: got pop=%0d pf=%0d, required 0/0",
                  n_pop - b_pop, n_pf - b_pf);
      end
      read_status("reset_mid_load");
      $display("test_reset_mid_load done");
   endtask

   task automatic test_random_frames(input int n);
      for (int t = 0; t < n; t++) begin
         int len = $urandom_range(0, 10);
         int ds, abort_at, nwr;
         bit pass, bogus, stop;
         logic [7:0] frame[$];
         int b_wr = wr_log.size();
         int b_pwi = n_pwi, b_pf = n_pf, b_pop = n_pop;
         if ($urandom_range(0, 1) == 1) ds = 1024 - len + int'($urandom_range(0, 2)) - 1;
         else ds = $urandom_range(0, 900);
         if (ds > 1024) ds = 1024;
         pass = (len != 0) && (ds + len <= 1024);
         abort_at = (pass && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         bogus = pass && ($urandom_range(0, 4) == 0);
         for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
         i_data_size = 16'(ds);
         send_byte(1'b1, 8'h01);
         idle($urandom_range(0, 2));
         send_byte(1'b0, 8'(len));
         idle($urandom_range(0, 2));
         send_byte(1'b0, 8'h00);
         stop = 1'b0;
         if (pass) begin
            for (int i = 0; i < len; i++) begin
               if (!stop) begin
                  idle($urandom_range(0, 2));
                  if (i == abort_at) begin
                     send_byte(1'b1, 8'h02);
                     stop = 1'b1;
                  end else begin
                     if (bogus && i == 0) send_byte(1'b1, 8'h07);
                     send_byte(1'b0, frame[i]);
                  end
               end
            end
         end
         if (!pass || bogus) exp_err = 1'b1;
         nwr = !pass ? 0 : (abort_at >= 0 ? abort_at : len);
         idle(3);
         n_cmp++;
         if (n_pwi - b_pwi !== int'(pass) || n_pop - b_pop !== int'(abort_at >= 0) ||
             n_pf - b_pf !== int'(pass && abort_at < 0) || wr_log.size() - b_wr !== nwr) begin
            n_err++;
            $display("FAIL rand %0d counts: got pwi=%0d pop=%0d pf=%0d wr=%0d, required %0d/%0d/%0d/%0d",
                     t, n_pwi - b_pwi, n_pop - b_pop, n_pf - b_pf, wr_log.size() - b_wr,
                     int'(pass), int'(abort_at >= 0), int'(pass && abort_at < 0), nwr);
         end
         for (int i = 0; i < nwr; i++) begin
            if (b_wr + i < wr_log.size()) begin
               n_cmp++;
               if (wr_log[b_wr + i] !== frame[i]) begin
                  n_err++;
                  $display("FAIL rand %0d byte %0d: got %h, required %h", t, i, wr_log[b_wr + i], frame[i]);
               end
            end
         end
         i_status = 8'($urandom);
         read_status("rand_status");
         $display("txn %0d len=%0d ds=%0d accepted=%0b abort_at=%0d bogus=%0b", t, len, ds, pass, abort_at, bogus);
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_overflow();
      test_abort();
      test_timeout();
      test_status();
      test_interrupt();
      test_reset_mid_load();
      test_random_frames(25);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/tx_host_ctrl.md
# tx_host_ctrl

Command sequencer between the byte-wide host port and the frame transmitter. It decodes host command and data bytes and turns them into transmitter write strobes, write-index save/restore and frame commits. It also serves status read-back and raises the TX-done interrupt. It runs in the `i_clk` domain and sits between the top-level host pins and the transmitter instance.

## Interface
- `BUF_BYTES`, 1024: transmitter buffer capacity in bytes; a frame that would overflow it is rejected.
- `TIMEOUT`, 4096: idle `i_clk` cycles allowed between host bytes inside a frame load before auto-abort.
- `i_clk` in 1: system clock; the only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_sync` in 1: host byte strobe, one cycle per byte.
- `i_cmd` in 1: qualifies `i_sync`; 1 = command byte, 0 = data byte.
- `i_data` in 8: host byte.
- `o_data` out 8: response byte.
- `o_sync` out 1: response byte strobe.
- `o_tx_int` out 1: TX-done interrupt, level, sticky.
- `o_tx_data` out 8: byte to the transmitter.
- `o_tx_data_we` out 1: transmitter write strobe.
- `o_push_write_index` out 1: one-cycle pulse; transmitter saves its write index.
- `o_pop_write_index` out 1: one-cycle pulse; transmitter restores the saved index, discarding the partial frame.
- `o_push_frame` out 1: one-cycle pulse; commit the loaded frame.
- `i_data_size` in 16: bytes currently held by the transmitter.
- `i_frames_count` in 8: frames queued in the transmitter.
- `i_status` in 8: transmitter status byte, passed through to the host.

## Operation
- **States:** IDLE, LEN_LO, LEN_HI, LOAD, RESP.
- **Commands**, accepted in IDLE when `i_sync & i_cmd`:
  - 0x01 BEGIN: go to LEN_LO.
  - 0x02 ABORT: no-op in IDLE.
  - 0x03 READ_STATUS: go to RESP.
  - 0x04 INT_ACK: clear `o_tx_int`.
  - Any other value: set `err`, stay in IDLE.
- **Length capture:**
  - LEN_LO takes a data byte as `len[7:0]`, then LEN_HI takes a data byte as `len[15:8]`.
  - On the LEN_HI byte, compute the check with a 17-bit sum: `len != 0` and `i_data_size + len <= BUF_BYTES`.
  - Pass: pulse `o_push_write_index`, load `remaining = len`, go to LOAD.
  - Fail: set `err`, go to IDLE. No transmitter strobes are issued.
- **LOAD:**
  - Each data byte is forwarded as `o_tx_data` with `o_tx_data_we`, and `remaining` decrements.
  - On the byte that brings `remaining` to 0, pulse `o_push_frame` and go to IDLE.
- **ABORT** in LEN_LO or LEN_HI: return to IDLE with no strobes.
- **ABORT** in LOAD: pulse `o_pop_write_index`, go to IDLE.
- **Errors:**
  - Any other command in LEN_LO, LEN_HI or LOAD: set `err`; the byte is ignored and the state is unchanged.
  - A data byte in IDLE: set `err`, ignored.
- **Timeout:**
  - The idle counter runs in LEN_LO, LEN_HI and LOAD, and clears on every `i_sync`.
  - When it reaches `TIMEOUT`, set `err` and go to IDLE. From LOAD this also pulses `o_pop_write_index`.
- **RESP:**
  - Emits 5 bytes: `{5'b0, loading, o_tx_int, err}`, `i_status`, `i_frames_count`, `i_data_size[7:0]`, `i_data_size[15:8]`.
  - All five are snapshotted on the READ_STATUS cycle; `loading` is 0 there, since RESP is only entered from IDLE.
  - `err` clears on the snapshot.
  - Any host byte that arrives during RESP is dropped and sets `err` again.
  - After the 5th byte, return to IDLE.
- **Interrupt:**
  - Register `i_frames_count` every cycle. When the new value is lower than the previous one, set `o_tx_int`.
  - If a set and an INT_ACK land in the same cycle, the set wins.

## Timing
- **Reset:** every output is 0. State = IDLE; `err`, `remaining`, the counters and the previous frame count are all 0.
- **Registered outputs:** all are registered. A host byte strobed at cycle t produces its transmitter strobe at t+1.
- **Write path:** `o_tx_data_we` and `o_tx_data` appear at t+1 for a data byte at t.
- **Commit:** `o_push_frame` appears at t+2 after the last data byte at t, so it never coincides with that byte's `o_tx_data_we`.
- **Index save:** `o_push_write_index` appears at t+1 after the LEN_HI byte at t.
- **Index restore:** `o_pop_write_index` appears at t+1 after an ABORT at t, or one cycle after the timeout hit.
- **Response:** `o_sync` is high for cycles t+1..t+5 after READ_STATUS at t, one byte per cycle. The host may send its next command at t+6.
- **Interrupt latency:** `o_tx_int` rises 2 cycles after `i_frames_count` drops.
- **Back-to-back bytes:** `i_sync` may be high every cycle.
- **Reset mid-LOAD:** no `o_pop_write_index` is issued. The transmitter is reset from the same source.

## Test plan
- **Normal frame:** cmd 0x01, data 0x03, 0x00, 0xAA, 0xBB, 0xCC. Expect one `o_push_write_index`, then three `o_tx_data_we` carrying AA/BB/CC in order, then one `o_push_frame`, then state back to IDLE.
- **Overflow reject:** `i_data_size`=1020 with `BUF_BYTES`=1024, load `len`=5. Expect no strobes; a following READ_STATUS returns byte0 = 0x01.
- **Abort mid-load:** after `len`=4 and 2 data bytes, send cmd 0x02. Expect exactly one `o_pop_write_index` and no `o_push_frame`.
- **Timeout:** with `TIMEOUT`=16, enter LOAD, send 1 byte, then idle for 16 cycles. Expect `o_pop_write_index` and `err`=1.
- **Status read-back:** with `i_status`=0x5A, `i_frames_count`=3, `i_data_size`=0x0123, send READ_STATUS. Expect 5 consecutive `o_sync` bytes 0x00, 0x5A, 0x03, 0x23, 0x01.
- **Interrupt:** step `i_frames_count` from 2 to 1. Expect `o_tx_int`=1. Send INT_ACK in the same cycle as a further drop from 1 to 0; expect `o_tx_int` stays 1. A later lone INT_ACK clears it.
